// File: rtl/scan_pkg.sv
// Shared FSM state type, bus widths and counter-width helper for frame_scan.
package scan_pkg;

  localparam int PIX_W   = 11;
  localparam int ADDRX_W = 11;
  localparam int ADDRY_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } scan_state_e;

  // Bits needed to hold 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_counter.sv
// Wrap counter 0..MAX-1 with terminal-count flag; used for both hcnt and vcnt.
module scan_counter
  import scan_pkg::*;
#(
  parameter int MAX = 2,
  parameter int W   = cnt_width(MAX)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  assign o_tc  = (r_cnt == W'(MAX - 1));
  assign o_cnt = r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= o_tc ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/frame_scan.sv
// Raster scanner: walks the frame, reads pixel memory and emits aligned video timing.
// Define SCAN_TEST_PATTERN_EN to replace memory data by addrX^addrY (rd held low).
module frame_scan
  import scan_pkg::*;
#(
  parameter int XSIZE  = 1280,
  parameter int YSIZE  = 800,
  parameter int HBLANK = 160,
  parameter int VBLANK = 23
) (
  input  logic               clkq,
  input  logic               rst_n,
  input  logic               enable,
  output logic [ADDRX_W-1:0] addrX,
  output logic [ADDRY_W-1:0] addrY,
  output logic               rd,
  input  logic [PIX_W-1:0]   d_in,
  output logic [PIX_W-1:0]   pix_out,
  output logic               de,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_start
);

  localparam int HTOTAL = XSIZE + HBLANK;
  localparam int VTOTAL = YSIZE + VBLANK;
  localparam int HW     = cnt_width(HTOTAL);
  localparam int VW     = cnt_width(VTOTAL);

  scan_state_e r_state;
  scan_state_e w_state_next;
  scan_state_e w_after_line;

  logic [HW-1:0] w_hcnt;
  logic [VW-1:0] w_vcnt;
  logic          w_h_tc;
  logic          w_v_tc;
  logic          w_run;
  logic          w_active;
  logic          w_hend;
  logic          w_last_line;

  assign w_run       = (r_state != ST_IDLE);
  assign w_active    = (r_state == ST_ACTIVE);
  assign w_hend      = (w_hcnt == HW'(XSIZE - 1));
  assign w_last_line = (w_vcnt == VW'(YSIZE - 1));

  scan_counter #(.MAX(HTOTAL), .W(HW)) u_hcnt (
    .i_clk   (clkq),
    .i_rst_n (rst_n),
    .i_clr   (!w_run),
    .i_inc   (w_run),
    .o_cnt   (w_hcnt),
    .o_tc    (w_h_tc)
  );

  scan_counter #(.MAX(VTOTAL), .W(VW)) u_vcnt (
    .i_clk   (clkq),
    .i_rst_n (rst_n),
    .i_clr   (!w_run),
    .i_inc   (w_run && w_h_tc),
    .o_cnt   (w_vcnt),
    .o_tc    (w_v_tc)
  );

  assign w_after_line = w_last_line ? ST_VBLANK : ST_ACTIVE;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (enable) w_state_next = ST_ACTIVE;
      ST_ACTIVE: if (w_hend) w_state_next = w_h_tc ? w_after_line : ST_HBLANK;
      ST_HBLANK: if (w_h_tc) w_state_next = w_after_line;
      // enable only matters here: a started frame always runs to completion
      ST_VBLANK: if (w_h_tc && w_v_tc) w_state_next = enable ? ST_ACTIVE : ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkq or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Stage 1: address / read strobe, plus timing flags for the same pixel.
  logic [ADDRX_W-1:0] r_addrx;
  logic [ADDRY_W-1:0] r_addry;
  logic               r_act1, r_hs1, r_vs1, r_fs1;

  always_ff @(posedge clkq or negedge rst_n) begin
    if (!rst_n) begin
      r_addrx <= '0;
      r_addry <= '0;
      r_act1  <= 1'b0;
      r_hs1   <= 1'b0;
      r_vs1   <= 1'b0;
      r_fs1   <= 1'b0;
    end else begin
      if (w_active) begin
        r_addrx <= ADDRX_W'(w_hcnt);
        r_addry <= ADDRY_W'(w_vcnt);
      end
      r_act1 <= w_active;
      r_hs1  <= w_run && (int'(w_hcnt) >= XSIZE);
      r_vs1  <= (r_state == ST_VBLANK);
      r_fs1  <= w_active && (w_hcnt == '0) && (w_vcnt == '0);
    end
  end

  // Stage 2: memory access cycle; d_in is valid while these are.
  logic             r_act2, r_hs2, r_vs2, r_fs2;
  logic [PIX_W-1:0] r_pat2;

  always_ff @(posedge clkq or negedge rst_n) begin
    if (!rst_n) begin
      r_act2 <= 1'b0;
      r_hs2  <= 1'b0;
      r_vs2  <= 1'b0;
      r_fs2  <= 1'b0;
      r_pat2 <= '0;
    end else begin
      r_act2 <= r_act1;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_fs2  <= r_fs1;
      r_pat2 <= PIX_W'(r_addrx) ^ PIX_W'(r_addry);
    end
  end

  logic [PIX_W-1:0] w_pix_src;

`ifdef SCAN_TEST_PATTERN_EN
  logic w_unused_din;
  assign w_unused_din = ^d_in;
  assign w_pix_src    = r_pat2;
  assign rd           = 1'b0;
`else
  logic [PIX_W-1:0] w_unused_pat;
  assign w_unused_pat = r_pat2;
  assign w_pix_src    = d_in;
  assign rd           = r_act1;
`endif

  // Stage 3: output register; pixel forced to zero outside the active region.
  logic [PIX_W-1:0] r_pix;
  logic             r_de, r_hsync, r_vsync, r_fs;

  always_ff @(posedge clkq or negedge rst_n) begin
    if (!rst_n) begin
      r_pix   <= '0;
      r_de    <= 1'b0;
      r_hsync <= 1'b0;
      r_vsync <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      r_pix   <= r_act2 ? w_pix_src : '0;
      r_de    <= r_act2;
      r_hsync <= r_hs2;
      r_vsync <= r_vs2;
      r_fs    <= r_fs2;
    end
  end

  assign addrX       = r_addrx;
  assign addrY       = r_addry;
  assign pix_out     = r_pix;
  assign de          = r_de;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_frame_scan.sv
// Randomized scoreboard bench for frame_scan using a frame-position reference model.
`timescale 1ns/1ps
module tb_frame_scan;

  localparam int XS = 4;
  localparam int YS = 2;
  localparam int HB = 2;
  localparam int VB = 1;
  localparam int HT = XS + HB;
  localparam int FT = HT * (YS + VB);

  logic        clkq   = 1'b0;
  logic        rst_n  = 1'b0;
  logic        enable = 1'b0;
  logic [10:0] addrX;
  logic [31:0] addrY;
  logic        rd;
  logic [10:0] d_in = '0;
  logic [10:0] pix_out;
  logic        de, hsync, vsync, frame_start;

  frame_scan #(.XSIZE(XS), .YSIZE(YS), .HBLANK(HB), .VBLANK(VB)) dut (
    .clkq        (clkq),
    .rst_n       (rst_n),
    .enable      (enable),
    .addrX       (addrX),
    .addrY       (addrY),
    .rd          (rd),
    .d_in        (d_in),
    .pix_out     (pix_out),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start)
  );

  always #5 clkq = ~clkq;

  typedef struct {
    logic [10:0] pix;
    logic        fs;
  } pix_t;

  logic [10:0] mem [YS][XS];
  pix_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          m_pos   = -1;
  int          m_lx    = 0;
  int          m_ly    = 0;
  int          h_pos[8] = '{default: -1};
  int          h_lx[8]  = '{default: 0};
  int          h_ly[8]  = '{default: 0};

  // Frame position p: line p/HT, pixel p%HT; -1 means not scanning.
  function automatic logic pos_act(input int p);
    return (p >= 0) && ((p % HT) < XS) && ((p / HT) < YS);
  endfunction
  function automatic logic pos_hs(input int p);
    return (p >= 0) && ((p % HT) >= XS);
  endfunction
  function automatic logic pos_vs(input int p);
    return (p >= 0) && ((p / HT) >= YS);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Memory: registered read one cycle after rd, junk otherwise.
  always @(posedge clkq) begin
    if (rd && addrX < XS && addrY < YS) d_in <= mem[addrY][addrX];
    else                                d_in <= 11'($urandom);
  end

  // Reference model: one position per cycle, expected pixels queued on issue.
  initial begin
    forever begin
      @(posedge clkq);
      cyc++;
      if (!rst_n) begin
        m_pos = -1;
        m_lx  = 0;
        m_ly  = 0;
        exp_q.delete();
      end else if (m_pos < 0 || m_pos == FT - 1) begin
        m_pos = enable ? 0 : -1;
      end else begin
        m_pos++;
      end
      if (pos_act(m_pos)) begin
        pix_t e;
        m_lx = m_pos % HT;
        m_ly = m_pos / HT;
`ifdef SCAN_TEST_PATTERN_EN
        e.pix = 11'(m_lx ^ m_ly);
`else
        e.pix = mem[m_ly][m_lx];
`endif
        e.fs = (m_pos == 0);
        exp_q.push_back(e);
      end
      h_pos[cyc % 8] = m_pos;
      h_lx[cyc % 8]  = m_lx;
      h_ly[cyc % 8]  = m_ly;
    end
  end

  // Monitor: address stage lags the position by 1 cycle, pixel stage by 3.
  initial begin
    forever begin
      @(negedge clkq);
      if (!rst_n) begin
        chk("reset_outputs", {addrX, addrY, rd, pix_out, de, hsync, vsync, frame_start}, 64'd0);
      end else begin
        int   i1, p1, p3;
        logic exp_rd;
        i1 = (cyc + 7) % 8;
        p1 = h_pos[i1];
        p3 = h_pos[(cyc + 5) % 8];
`ifdef SCAN_TEST_PATTERN_EN
        exp_rd = 1'b0;
`else
        exp_rd = pos_act(p1);
`endif
        chk("rd", rd, exp_rd);
        chk("addrX", addrX, h_lx[i1]);
        chk("addrY", addrY, h_ly[i1]);
        chk("de", de, pos_act(p3));
        chk("hsync", hsync, pos_hs(p3));
        chk("vsync", vsync, pos_vs(p3));
        if (de) begin
          if (exp_q.size() == 0) begin
            chk("de_without_pixel", de, 1'b0);
          end else begin
            pix_t e;
            e = exp_q.pop_front();
            $display("[TB] cyc=%0d pixel pix_out=%0d frame_start=%0d", cyc, pix_out, frame_start);
            chk("pix_out", pix_out, e.pix);
            chk("frame_start", frame_start, e.fs);
          end
        end else begin
          chk("pix_out_blank", pix_out, 11'd0);
          chk("frame_start_blank", frame_start, 1'b0);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clkq);
  endtask

  // Called at a negedge; asserts reset mid-cycle and checks the async clear.
  task automatic do_reset(input int n);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {addrX, addrY, rd, pix_out, de, hsync, vsync, frame_start}, 64'd0);
    repeat (n) @(negedge clkq);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_pos(input int target);
    int k;
    k = 0;
    while (m_pos != target && k < 200) begin
      @(negedge clkq);
      k++;
    end
    if (m_pos != target) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_pos timeout got=%0d expected=%0d", m_pos, target);
    end
  endtask

  initial begin
    for (int y = 0; y < YS; y++)
      for (int x = 0; x < XS; x++)
        mem[y][x] = 11'($urandom);

    cycles(4);
    #2 rst_n = 1'b1;
    cycles(5);

    enable = 1'b1;
    cycles(3 * FT);

    // Drop enable at line 0, pixel 2: frame must still complete.
    wait_pos(2);
    enable = 1'b0;
    cycles(2 * FT);

    for (int i = 0; i < 30; i++) begin
      enable = 1'($urandom_range(0, 1));
      cycles($urandom_range(1, 3 * FT));
      if ($urandom_range(0, 7) == 0) do_reset($urandom_range(4, 6));
    end

    // Reset at line 1, pixel 1 with enable held: restart from (0,0).
    enable = 1'b1;
    wait_pos(HT + 1);
    do_reset(4);
    cycles(2 * FT);

    enable = 1'b0;
    cycles(FT + 6);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
